deser_stream_w: RTL and testbench
=================================

// Module: deser_stream_w
//
// PURPOSE
// Parametrised multi-lane serial-to-parallel deserialiser with valid/ready output.
// Collects LANES bits per accepted beat into a DESER_W-bit word.
// - Bit order is selectable per word (MSB- or LSB-first).
// - A partial word can be flushed out with a fill count.
// - A one-word holding stage absorbs output backpressure.
// Sits between a serial link front-end and word-wide consumers that may stall.
//
// PARAMETERS
// DESER_W  16  output word width in bits; must be >= 2
// LANES    1   serial bits per beat; DESER_W % LANES must be 0
//
// PORTS
// clk_i              in   1                      clock; all logic on rising edge
// srst_i             in   1                      reset, asynchronous, active-high
// data_val_i         in   1                      beat on data_i valid this cycle
// data_i             in   LANES                  serial beat; data_i[LANES-1] is the higher-order bit
// msb_first_i        in   1                      1: MSB-first, 0: LSB-first; sampled on beat 0 of a word
// flush_i            in   1                      emit the current partial word
// deser_data_o       out  DESER_W                assembled word
// deser_cnt_o        out  $clog2(DESER_W+1)      valid bits in deser_data_o (DESER_W for a full word)
// deser_data_val_o   out  1                      deser_data_o and deser_cnt_o valid
// deser_data_ready_i in   1                      consumer accepts the word when high with deser_data_val_o
// busy_o             out  1                      accumulator non-empty or holding a word
// overflow_o         out  1                      one-cycle pulse: a valid beat was dropped
//
// BEHAVIOUR
// - Reset (asynchronous):
//   - All outputs are 0; state goes to IDLE; accumulator, beat counter and order flag clear.
//   - Reset mid-word discards the partial word; no output is produced for it.
// - Beats per word: B = DESER_W/LANES.
// - Placement of beat k (0-based):
//   - MSB-first: acc[DESER_W-1-k*LANES -: LANES] <= data_i.
//   - LSB-first: acc[k*LANES +: LANES] <= data_i.
// - Accumulator states:
//   - IDLE: count == 0. A beat moves to COLLECT, or straight to FULL when B == 1.
//   - COLLECT: accepts beats. On beat B-1, or on flush_i, the word is complete: go to FULL.
//   - FULL: accumulator holds a complete word waiting for the output stage.
//     Beats arriving here are dropped and overflow_o pulses for each.
// - Word order: the order flag latches msb_first_i on beat 0. Changes of msb_first_i mid-word are ignored.
// - Flush:
//   - flush_i with data_val_i in the same cycle: the beat is stored first, then the flush applies.
//   - flush_i with count == 0 and no beat: no effect.
//   - A flush that coincides with beat B-1 gives an ordinary full word (cnt = DESER_W).
//   - Partial word: unfilled bits are 0; cnt = beats*LANES; filled bits stay in their normal positions.
// - Output stage:
//   - The accumulator word moves to the output register when state is FULL and (!deser_data_val_o || deser_data_ready_i).
//   - In the same cycle the accumulator returns to IDLE. A beat arriving that cycle is accepted as beat 0 of the next word, not dropped.
//   - Latency: a completing beat or flush in cycle N gives deser_data_val_o = 1 in cycle N+1 if the output stage is free.
//   - Full throughput, one word per B beats, with ready held high.
//   - While deser_data_val_o = 1 and deser_data_ready_i = 0, deser_data_o and deser_cnt_o are stable.
//   - After a handshake with no new word, val drops to 0; data and cnt keep their last values.
// - busy_o = (state != IDLE) || deser_data_val_o.
// - Beat counter width is $clog2(B+1) bits; no wrap beyond B-1.
//
// TESTING
// - DESER_W=8, LANES=1, MSB-first, ready=1, serial 1,0,1,1,0,0,1,0
//   -> data=8'hB2, cnt=8, val high for exactly 1 cycle, the cycle after the 8th beat.
// - Same bits, LSB-first -> data=8'h4D, cnt=8.
// - DESER_W=16, LANES=4, MSB-first, nibbles A,B,C,D -> 16'hABCD.
//   Then 3 nibbles 1,2,3 plus flush_i on the 3rd -> data=16'h1230, cnt=12.
// - DESER_W=8, LANES=1, ready=0: send two full words -> word 1 held stable on the output, word 2 held in the accumulator.
//   Further beats -> overflow_o pulse per beat. Raise ready -> word 1 then word 2, each 1 cycle apart, no loss.
// - Assert srst_i after 5 beats of a word -> all outputs 0 immediately (asynchronously).
//   A full word after release is correct, with no remnant bits.
// - Continuous beats with ready=1 for 100 random words, random per-word order
//   -> output matches the model, no overflow_o, val asserted every B cycles.

Source files
------------

// File: rtl/deser_stream_w.sv
// Multi-lane serial-to-parallel deserialiser with per-word bit order, partial-word
// flush and a one-word output holding stage behind a valid/ready handshake.
module deser_stream_w #(
  parameter int DESER_W = 16,
  parameter int LANES   = 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         data_val_i,
  input  logic [LANES-1:0]             data_i,
  input  logic                         msb_first_i,
  input  logic                         flush_i,
  output logic [DESER_W-1:0]           deser_data_o,
  output logic [$clog2(DESER_W+1)-1:0] deser_cnt_o,
  output logic                         deser_data_val_o,
  input  logic                         deser_data_ready_i,
  output logic                         busy_o,
  output logic                         overflow_o
);

  localparam int B      = DESER_W / LANES;
  localparam int CNT_W  = $clog2(DESER_W + 1);
  localparam int BCNT_W = $clog2(B + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_e;

  state_e              state_q;
  logic [DESER_W-1:0]  acc_q, acc_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                msb_q, msb_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [DESER_W-1:0]  out_data_q;
  logic [CNT_W-1:0]    out_cnt_q;
  logic                out_val_q;
  logic                overflow_q;

  logic                out_free;
  logic                load_full;
  logic                load_new;
  logic                accept;
  logic                first_beat;
  logic                complete;
  logic [BCNT_W-1:0]   slot_cnt;
  logic [BCNT_W-1:0]   slot_pos;

  // NOTE: every variable gets a default at the top of the block so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    out_free   = !out_val_q || deser_data_ready_i;
    load_full  = (state_q == S_FULL) && out_free;
    // A FULL accumulator that drains this cycle can take beat 0 of the next word.
    accept     = data_val_i && ((state_q != S_FULL) || load_full);
    first_beat = (state_q != S_COLLECT);
    slot_cnt   = first_beat ? '0 : beat_cnt_q;
    msb_d      = first_beat ? msb_first_i : msb_q;
    slot_pos   = msb_d ? (BCNT_W'(B - 1) - slot_cnt) : slot_cnt;

    // Starting beat 0 from zero keeps unfilled bits of a flushed word at 0.
    acc_d = first_beat ? '0 : acc_q;
    if (accept) begin
      for (int b = 0; b < B; b++) begin
        if (BCNT_W'(b) == slot_pos) acc_d[b*LANES +: LANES] = data_i;
      end
    end

    beat_cnt_d = accept ? (slot_cnt + BCNT_W'(1)) : beat_cnt_q;
    complete   = accept ? ((beat_cnt_d == BCNT_W'(B)) || flush_i)
                        : (flush_i && (state_q == S_COLLECT));
    word_cnt_d = CNT_W'(int'(beat_cnt_d) * LANES);
    // A word completing into a free output stage bypasses FULL for 1-cycle latency.
    load_new   = complete && out_free && (state_q != S_FULL);
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      msb_q      <= 1'b0;
      word_cnt_q <= '0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_val_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= data_val_i && !accept;

      if (load_full) begin
        out_data_q <= acc_q;
        out_cnt_q  <= word_cnt_q;
        out_val_q  <= 1'b1;
      end else if (load_new) begin
        out_data_q <= acc_d;
        out_cnt_q  <= word_cnt_d;
        out_val_q  <= 1'b1;
      end else if (deser_data_ready_i) begin
        out_val_q  <= 1'b0;
      end

      if (accept) begin
        acc_q <= acc_d;
        msb_q <= msb_d;
      end

      if (complete) begin
        if (load_new) begin
          state_q    <= S_IDLE;
          beat_cnt_q <= '0;
        end else begin
          state_q    <= S_FULL;
          word_cnt_q <= word_cnt_d;
          beat_cnt_q <= beat_cnt_d;
        end
      end else if (accept) begin
        state_q    <= S_COLLECT;
        beat_cnt_q <= beat_cnt_d;
      end else if (load_full) begin
        state_q    <= S_IDLE;
        beat_cnt_q <= '0;
      end
    end
  end

  assign deser_data_o     = out_data_q;
  assign deser_cnt_o      = out_cnt_q;
  assign deser_data_val_o = out_val_q;
  assign overflow_o       = overflow_q;
  assign busy_o           = (state_q != S_IDLE) || out_val_q;

endmodule

// File: tb/tb_deser_stream_w.sv
// Bench for deser_stream_w: an 8x1 and a 16x4 instance checked against word values
// built arithmetically from the beats that were sent.
module tb_deser_stream_w;

  logic clk;
  logic srst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       v8, d8, msb8, fl8, rdy8;
  logic [7:0] q8;
  logic [3:0] c8;
  logic       qv8, busy8, ov8;

  logic        v16, msb16, fl16, rdy16;
  logic [3:0]  d16;
  logic [15:0] q16;
  logic [4:0]  c16;
  logic        qv16, busy16, ov16;

  int passed = 0;
  int total  = 0;

  deser_stream_w #(.DESER_W(8), .LANES(1)) dut8 (
    .clk_i(clk), .srst_i(srst), .data_val_i(v8), .data_i(d8), .msb_first_i(msb8),
    .flush_i(fl8), .deser_data_o(q8), .deser_cnt_o(c8), .deser_data_val_o(qv8),
    .deser_data_ready_i(rdy8), .busy_o(busy8), .overflow_o(ov8)
  );

  deser_stream_w #(.DESER_W(16), .LANES(4)) dut16 (
    .clk_i(clk), .srst_i(srst), .data_val_i(v16), .data_i(d16), .msb_first_i(msb16),
    .flush_i(fl16), .deser_data_o(q16), .deser_cnt_o(c16), .deser_data_val_o(qv16),
    .deser_data_ready_i(rdy16), .busy_o(busy16), .overflow_o(ov16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference word: MSB-first shifts earlier beats toward the top, LSB-first
  // places beat k at k*4; a partial word is left-aligned / zero-filled.
  function automatic logic [15:0] model16(input logic [3:0] nib [4], input bit msb, input int n);
    int w;
    w = 0;
    for (int i = 0; i < n; i++) begin
      if (msb) w = w * 16 + int'(nib[i]);
      else     w = w + (int'(nib[i]) << (4 * i));
    end
    if (msb) w = w << (4 * (4 - n));
    return w[15:0];
  endfunction

  task automatic send8(input logic [7:0] seq, input logic msb, input string name);
    for (int i = 0; i < 8; i++) begin
      v8 = 1'b1; d8 = seq[7-i]; msb8 = msb;
      tick();
      if (i < 7) begin
        total++;
        if (qv8 !== 1'b0) $display("FAIL %s_early_val beat=%0d val=%b want=0", name, i, qv8);
        else passed++;
      end
    end
    v8 = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    v8 = 0; d8 = 0; msb8 = 1; fl8 = 0; rdy8 = 1;
    v16 = 0; d16 = 0; msb16 = 1; fl16 = 0; rdy16 = 1;
    tick();
    tick();
    total++;
    if ({qv8, q8, c8, busy8, ov8} !== 15'd0)
      $display("FAIL reset8 outs=%h want=0", {qv8, q8, c8, busy8, ov8});
    else passed++;
    total++;
    if ({qv16, q16, c16, busy16, ov16} !== 24'd0)
      $display("FAIL reset16 outs=%h want=0", {qv16, q16, c16, busy16, ov16});
    else passed++;
    srst = 1'b0;
    tick();
  endtask

  task automatic test_bit_order();
    send8(8'b1011_0010, 1'b1, "msb");
    total++;
    if ({qv8, q8, c8} !== {1'b1, 8'hB2, 4'd8})
      $display("FAIL msb_word val=%b data=%h cnt=%0d want 1/b2/8", qv8, q8, c8);
    else passed++;
    tick();
    total++;
    if (qv8 !== 1'b0) $display("FAIL msb_val_width val=%b want=0", qv8);
    else passed++;
    send8(8'b1011_0010, 1'b0, "lsb");
    total++;
    if ({qv8, q8, c8} !== {1'b1, 8'h4D, 4'd8})
      $display("FAIL lsb_word val=%b data=%h cnt=%0d want 1/4d/8", qv8, q8, c8);
    else passed++;
    tick();
  endtask

  task automatic test_lanes_flush();
    logic [3:0] nibs [4];
    nibs[0] = 4'hA; nibs[1] = 4'hB; nibs[2] = 4'hC; nibs[3] = 4'hD;
    for (int i = 0; i < 4; i++) begin
      v16 = 1'b1; d16 = nibs[i]; msb16 = 1'b1; tick();
    end
    v16 = 1'b0;
    total++;
    if ({qv16, q16, c16} !== {1'b1, 16'hABCD, 5'd16})
      $display("FAIL lanes_word val=%b data=%h cnt=%0d want 1/abcd/16", qv16, q16, c16);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      v16 = 1'b1; d16 = 4'(i + 1); fl16 = (i == 2); tick();
    end
    v16 = 1'b0; fl16 = 1'b0;
    total++;
    if ({qv16, q16, c16} !== {1'b1, 16'h1230, 5'd12})
      $display("FAIL flush_partial val=%b data=%h cnt=%0d want 1/1230/12", qv16, q16, c16);
    else passed++;
    tick();
    total++;
    if ({qv16, busy16} !== 2'b00) $display("FAIL flush_drain val/busy=%b want=00", {qv16, busy16});
    else passed++;
    fl16 = 1'b1; tick(); fl16 = 1'b0; tick();
    total++;
    if ({qv16, busy16} !== 2'b00) $display("FAIL flush_empty val/busy=%b want=00", {qv16, busy16});
    else passed++;
  endtask

  task automatic test_backpressure();
    rdy8 = 1'b0;
    send8(8'hC3, 1'b1, "bp1");
    total++;
    if ({qv8, q8, c8} !== {1'b1, 8'hC3, 4'd8})
      $display("FAIL bp_word1 val=%b data=%h cnt=%0d want 1/c3/8", qv8, q8, c8);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      v8 = 1'b1; d8 = (i % 2 == 1); msb8 = 1'b1; tick();
      total++;
      if ({qv8, q8} !== {1'b1, 8'hC3}) $display("FAIL bp_hold beat=%0d val=%b data=%h want 1/c3", i, qv8, q8);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; d8 = 1'b1; tick();
      total++;
      if (ov8 !== 1'b1) $display("FAIL bp_overflow beat=%0d ovf=%b want=1", i, ov8);
      else passed++;
    end
    v8 = 1'b0; tick();
    total++;
    if ({ov8, busy8, qv8, q8} !== {1'b0, 1'b1, 1'b1, 8'hC3})
      $display("FAIL bp_idle ovf/busy/val/data=%h want 0/1/1/c3", {ov8, busy8, qv8, q8});
    else passed++;
    rdy8 = 1'b1; tick();
    total++;
    if ({qv8, q8, c8} !== {1'b1, 8'h55, 4'd8})
      $display("FAIL bp_word2 val=%b data=%h cnt=%0d want 1/55/8", qv8, q8, c8);
    else passed++;
    tick();
    total++;
    if ({qv8, q8, busy8} !== {1'b0, 8'h55, 1'b0})
      $display("FAIL bp_done val=%b data=%h busy=%b want 0/55/0", qv8, q8, busy8);
    else passed++;
  endtask

  task automatic test_reset_midword();
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; d8 = 1'b1; msb8 = 1'b1; tick();
    end
    v8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) $display("FAIL midword_busy busy=%b want=1", busy8);
    else passed++;
    #2 srst = 1'b1;
    #1;
    total++;
    if ({qv8, q8, c8, busy8, ov8} !== 15'd0)
      $display("FAIL async_reset outs=%h want=0", {qv8, q8, c8, busy8, ov8});
    else passed++;
    #1 srst = 1'b0;
    send8(8'h01, 1'b1, "post_rst");
    total++;
    if ({qv8, q8, c8} !== {1'b1, 8'h01, 4'd8})
      $display("FAIL post_reset_word val=%b data=%h cnt=%0d want 1/01/8", qv8, q8, c8);
    else passed++;
    tick();
  endtask

  task automatic test_random_stream();
    logic [3:0]  nibs [4];
    logic [15:0] exp_w;
    bit          msb;
    rdy16 = 1'b1;
    for (int w = 0; w < 100; w++) begin
      msb = bit'($urandom_range(1));
      for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom_range(15));
      exp_w = model16(nibs, msb, 4);
      for (int k = 0; k < 4; k++) begin
        v16 = 1'b1; d16 = nibs[k];
        msb16 = (k == 0) ? msb : 1'($urandom_range(1));
        tick();
        total++;
        if (ov16 !== 1'b0) $display("FAIL rand_overflow word=%0d beat=%0d ovf=%b want=0", w, k, ov16);
        else passed++;
        total++;
        if (qv16 !== (k == 3)) $display("FAIL rand_val word=%0d beat=%0d val=%b want=%b", w, k, qv16, (k == 3));
        else passed++;
        if (k == 3) begin
          total++;
          if ({q16, c16} !== {exp_w, 5'd16})
            $display("FAIL rand_word word=%0d msb=%0d data=%h cnt=%0d want %h/16", w, msb, q16, c16, exp_w);
          else passed++;
        end
      end
    end
    v16 = 1'b0;
    tick();
    total++;
    if ({qv16, busy16} !== 2'b00) $display("FAIL rand_end val/busy=%b want=00", {qv16, busy16});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_lanes_flush();
    test_backpressure();
    test_reset_midword();
    test_random_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
